// File: rtl/vga_timing_ctrl.sv
// VGA raster timing: free-running line/frame counters, sync and display-enable
// generation, a one-cycle-early pixel request, and a frame-stable sprite position.
module vga_timing_ctrl #(
  parameter int unsigned H_SYNC  = 96,
  parameter int unsigned H_BACK  = 48,
  parameter int unsigned H_VALID = 640,
  parameter int unsigned H_FRONT = 16,
  parameter int unsigned V_SYNC  = 2,
  parameter int unsigned V_BACK  = 33,
  parameter int unsigned V_VALID = 480,
  parameter int unsigned V_FRONT = 10,
  parameter int unsigned PIC_W   = 100
) (
  input  logic        vga_clk,
  input  logic        sys_rst,
  input  logic [15:0] pix_data,
  input  logic [9:0]  x_move_in,
  input  logic [9:0]  y_move_in,
  output logic [11:0] pix_x,
  output logic [11:0] pix_y,
  output logic [9:0]  x_move,
  output logic [9:0]  y_move,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [15:0] rgb,
  output logic        frame_start
);

  localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;
  localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;

  localparam logic [11:0] H_LAST  = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST  = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_SYNC_W = 12'(H_SYNC);
  localparam logic [11:0] V_SYNC_W = 12'(V_SYNC);
  localparam logic [11:0] H_ACT_S = 12'(H_SYNC + H_BACK);
  localparam logic [11:0] H_ACT_E = 12'(H_SYNC + H_BACK + H_VALID);
  localparam logic [11:0] H_REQ_S = 12'(H_SYNC + H_BACK - 1);
  localparam logic [11:0] H_REQ_E = 12'(H_SYNC + H_BACK + H_VALID - 1);
  localparam logic [11:0] V_ACT_S = 12'(V_SYNC + V_BACK);
  localparam logic [11:0] V_ACT_E = 12'(V_SYNC + V_BACK + V_VALID);
  localparam logic [9:0]  X_MAX   = 10'(H_VALID - PIC_W);
  localparam logic [9:0]  Y_MAX   = 10'(V_VALID - PIC_W);

  logic [11:0] cnt_h;
  logic [11:0] cnt_v;
  logic        h_last;
  logic        v_last;
  logic        h_act;
  logic        v_act;
  logic        pix_req;

  assign h_last = (cnt_h == H_LAST);
  assign v_last = (cnt_v == V_LAST);

  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt_h <= '0;
      cnt_v <= '0;
    end else if (h_last) begin
      cnt_h <= '0;
      cnt_v <= v_last ? '0 : cnt_v + 12'd1;
    end else begin
      cnt_h <= cnt_h + 12'd1;
    end
  end

  // Pulse is registered from the last position so it lines up with cnt = (0,0).
  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= h_last && v_last;
    end
  end

  // Sprite position is sampled only at the frame boundary so it holds for a whole frame.
  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      x_move <= '0;
      y_move <= '0;
    end else if (h_last && v_last) begin
      x_move <= (x_move_in > X_MAX) ? X_MAX : x_move_in;
      y_move <= (y_move_in > Y_MAX) ? Y_MAX : y_move_in;
    end
  end

  always_comb begin
    hsync   = (cnt_h < H_SYNC_W);
    vsync   = (cnt_v < V_SYNC_W);
    h_act   = (cnt_h >= H_ACT_S) && (cnt_h < H_ACT_E);
    v_act   = (cnt_v >= V_ACT_S) && (cnt_v < V_ACT_E);
    pix_req = v_act && (cnt_h >= H_REQ_S) && (cnt_h < H_REQ_E);
    de      = h_act && v_act;
    pix_x   = pix_req ? (cnt_h - H_REQ_S) : '1;
    pix_y   = pix_req ? (cnt_v - V_ACT_S) : '1;
    rgb     = de ? pix_data : '0;
  end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: a full-size instance checked through the first visible
// lines and a shrunken-timing instance exercised across several whole frames.
module tb_vga_timing_ctrl;

  // Reduced timing for the frame-level instance.
  localparam int SHS = 4, SHB = 3, SHV = 16, SHF = 2;
  localparam int SVS = 2, SVB = 3, SVV = 10, SVF = 2;
  localparam int SPW = 5;
  localparam int SHT = SHS + SHB + SHV + SHF;   // 25
  localparam int SVT = SVS + SVB + SVV + SVF;   // 17
  localparam longint SF = SHT * SVT;            // 425
  localparam longint BF = 800 * 525;            // 420000

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic        fs;
    logic [11:0] px;
    logic [11:0] py;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Full-size instance
  logic        rst_b;
  logic [15:0] pix_b;
  logic [9:0]  x_in_b, y_in_b;
  logic [11:0] pix_x_b, pix_y_b;
  logic [9:0]  x_move_b, y_move_b;
  logic        hsync_b, vsync_b, de_b, fs_b;
  logic [15:0] rgb_b;

  // Shrunken instance
  logic        rst_s;
  logic [15:0] pix_s;
  logic [9:0]  x_in_s, y_in_s;
  logic [11:0] pix_x_s, pix_y_s;
  logic [9:0]  x_move_s, y_move_s;
  logic        hsync_s, vsync_s, de_s, fs_s;
  logic [15:0] rgb_s;

  vga_timing_ctrl dut (
    .vga_clk(clk), .sys_rst(rst_b), .pix_data(pix_b),
    .x_move_in(x_in_b), .y_move_in(y_in_b),
    .pix_x(pix_x_b), .pix_y(pix_y_b), .x_move(x_move_b), .y_move(y_move_b),
    .hsync(hsync_b), .vsync(vsync_b), .de(de_b), .rgb(rgb_b), .frame_start(fs_b)
  );

  vga_timing_ctrl #(
    .H_SYNC(SHS), .H_BACK(SHB), .H_VALID(SHV), .H_FRONT(SHF),
    .V_SYNC(SVS), .V_BACK(SVB), .V_VALID(SVV), .V_FRONT(SVF), .PIC_W(SPW)
  ) dut_s (
    .vga_clk(clk), .sys_rst(rst_s), .pix_data(pix_s),
    .x_move_in(x_in_s), .y_move_in(y_in_s),
    .pix_x(pix_x_s), .pix_y(pix_y_s), .x_move(x_move_s), .y_move(y_move_s),
    .hsync(hsync_s), .vsync(vsync_s), .de(de_s), .rgb(rgb_s), .frame_start(fs_s)
  );

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Expected outputs from the number of clock edges since reset.
  function automatic exp_t model_out(input longint t, input int hs, input int hb,
                                     input int hv, input int hf, input int vs,
                                     input int vb, input int vv, input int vf);
    exp_t   e;
    longint ht, vt, h, v;
    logic   hact, vact, req;
    ht   = hs + hb + hv + hf;
    vt   = vs + vb + vv + vf;
    h    = t % ht;
    v    = (t / ht) % vt;
    hact = (h >= hs + hb) && (h < hs + hb + hv);
    vact = (v >= vs + vb) && (v < vs + vb + vv);
    req  = vact && (h + 1 >= hs + hb) && (h + 1 < hs + hb + hv);
    e.hs = (h < hs);
    e.vs = (v < vs);
    e.de = hact && vact;
    e.fs = (t != 0) && (t % (ht * vt) == 0);
    e.px = req ? 12'(h + 1 - (hs + hb)) : 12'hFFF;
    e.py = req ? 12'(v - (vs + vb)) : 12'hFFF;
    return e;
  endfunction

  // Model state: edge counts and latched sprite position.
  longint    tb_t, ts_t;
  logic [9:0] bmx, bmy, smx, smy;

  always @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      tb_t <= 0; bmx <= '0; bmy <= '0;
    end else begin
      if (tb_t % BF == BF - 1) begin
        bmx <= (x_in_b > 10'd540) ? 10'd540 : x_in_b;
        bmy <= (y_in_b > 10'd380) ? 10'd380 : y_in_b;
      end
      tb_t <= tb_t + 1;
    end
  end

  always @(posedge clk or posedge rst_s) begin
    if (rst_s) begin
      ts_t <= 0; smx <= '0; smy <= '0;
    end else begin
      if (ts_t % SF == SF - 1) begin
        smx <= (x_in_s > 10'(SHV - SPW)) ? 10'(SHV - SPW) : x_in_s;
        smy <= (y_in_s > 10'(SVV - SPW)) ? 10'(SVV - SPW) : y_in_s;
      end
      ts_t <= ts_t + 1;
    end
  end

  exp_t eb, es;
  int   hs_cnt0 = 0;
  int   n_de = 0, n_red = 0;

  always @(negedge clk) begin
    eb = model_out(tb_t, 96, 48, 640, 16, 2, 33, 480, 10);
    chk("b_hsync", hsync_b, eb.hs);
    chk("b_vsync", vsync_b, eb.vs);
    chk("b_de", de_b, eb.de);
    chk("b_frame_start", fs_b, eb.fs);
    chk("b_pix_x", pix_x_b, eb.px);
    chk("b_pix_y", pix_y_b, eb.py);
    chk("b_rgb", rgb_b, eb.de ? pix_b : 16'h0000);
    chk("b_x_move", x_move_b, bmx);
    chk("b_y_move", y_move_b, bmy);
    if (!rst_b) begin
      if (tb_t < 800 && hsync_b) hs_cnt0++;
      if (tb_t == 800) chk("line0_hsync_cycles", hs_cnt0, 96);
      if (tb_t == 1599) chk("line1_vsync", vsync_b, 1);
      if (tb_t == 1600) chk("line2_vsync", vsync_b, 0);
      if (tb_t == 35 * 800 + 143) begin
        chk("l35_h143_pix_x", pix_x_b, 0);
        chk("l35_h143_pix_y", pix_y_b, 0);
        chk("l35_h143_de", de_b, 0);
      end
      if (tb_t == 35 * 800 + 144) begin
        chk("l35_h144_de", de_b, 1);
        chk("l35_h144_rgb", rgb_b, pix_b);
      end
      if (tb_t == 35 * 800 + 782) chk("l35_h782_pix_x", pix_x_b, 639);
      if (tb_t == 35 * 800 + 783) begin
        chk("l35_h783_pix_x", pix_x_b, 12'hFFF);
        chk("l35_h783_de", de_b, 1);
      end
      if (tb_t == 35 * 800 + 784) chk("l35_h784_de", de_b, 0);
    end
  end

  always @(negedge clk) begin
    es = model_out(ts_t, SHS, SHB, SHV, SHF, SVS, SVB, SVV, SVF);
    chk("s_hsync", hsync_s, es.hs);
    chk("s_vsync", vsync_s, es.vs);
    chk("s_de", de_s, es.de);
    chk("s_frame_start", fs_s, es.fs);
    chk("s_pix_x", pix_x_s, es.px);
    chk("s_pix_y", pix_y_s, es.py);
    chk("s_rgb", rgb_s, es.de ? pix_s : 16'h0000);
    chk("s_x_move", x_move_s, smx);
    chk("s_y_move", y_move_s, smy);
    if (!rst_s && ts_t >= 4 * SF && ts_t < 5 * SF) begin
      if (de_s) n_de++;
      if (rgb_s == 16'hF800) n_red++;
    end
  end

  // Pixel data changes every cycle, except a constant colour held over one small frame.
  logic hold_red = 1'b0;
  initial begin
    pix_b = 16'h1234;
    pix_s = 16'h4321;
    forever begin
      @(posedge clk);
      #1;
      pix_b = 16'($urandom);
      pix_s = hold_red ? 16'hF800 : 16'($urandom);
    end
  end

  task automatic wait_t(input longint target);
    int n = 0;
    while (ts_t != target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (ts_t != target) chk("wait_timeout", ts_t, target);
  endtask

  task automatic chk_reset_state(input string tag, input logic hs, input logic vs,
                                 input logic d, input logic fs, input logic [11:0] px,
                                 input logic [11:0] py, input logic [9:0] xm,
                                 input logic [9:0] ym, input logic [15:0] c);
    chk({tag, "_hsync"}, hs, 1);
    chk({tag, "_vsync"}, vs, 1);
    chk({tag, "_de"}, d, 0);
    chk({tag, "_frame_start"}, fs, 0);
    chk({tag, "_pix_x"}, px, 12'hFFF);
    chk({tag, "_pix_y"}, py, 12'hFFF);
    chk({tag, "_x_move"}, xm, 0);
    chk({tag, "_y_move"}, ym, 0);
    chk({tag, "_rgb"}, c, 0);
  endtask

  initial begin
    int n;
    rst_b = 1'b1; rst_s = 1'b1;
    x_in_b = 10'd600; y_in_b = 10'd50;
    x_in_s = 10'd600; y_in_s = 10'd3;
    repeat (3) @(negedge clk);
    chk_reset_state("rst_b", hsync_b, vsync_b, de_b, fs_b, pix_x_b, pix_y_b,
                    x_move_b, y_move_b, rgb_b);
    chk_reset_state("rst_s", hsync_s, vsync_s, de_s, fs_s, pix_x_s, pix_y_s,
                    x_move_s, y_move_s, rgb_s);
    rst_b = 1'b0; rst_s = 1'b0;

    // Capture with clamping (x clamps to 11, y passes through).
    wait_t(SF);
    chk("cap1_x_move", x_move_s, 11);
    chk("cap1_y_move", y_move_s, 3);

    // Mid-frame change has no effect until the next boundary.
    x_in_s = 10'd7; y_in_s = 10'd0;
    wait_t(2 * SF);
    chk("cap2_x_move", x_move_s, 7);
    chk("cap2_y_move", y_move_s, 0);
    wait_t(2 * SF + 200);
    x_in_s = 10'd9;
    wait_t(2 * SF + 300);
    chk("hold_x_move", x_move_s, 7);
    wait_t(3 * SF);
    chk("cap3_x_move", x_move_s, 9);

    // Just above the clamp and a large value at the 10-bit top.
    x_in_s = 10'd12; y_in_s = 10'd1023;
    wait_t(4 * SF - 1);
    hold_red = 1'b1;
    wait_t(4 * SF);
    chk("cap4_x_move", x_move_s, 11);
    chk("cap4_y_move", y_move_s, 5);
    chk("cap4_frame_start", fs_s, 1);
    wait_t(5 * SF);
    hold_red = 1'b0;
    chk("frame_de_cycles", n_de, SHV * SVV);
    chk("frame_red_cycles", n_red, SHV * SVV);

    // Asynchronous reset mid-frame (line 8, cnt_h 12).
    wait_t(5 * SF + 8 * SHT + 12);
    #2;
    rst_s = 1'b1;
    #1;
    chk_reset_state("async_rst", hsync_s, vsync_s, de_s, fs_s, pix_x_s, pix_y_s,
                    x_move_s, y_move_s, rgb_s);
    @(negedge clk);
    @(negedge clk);
    rst_s = 1'b0;
    n = 0;
    while (n < 2 * SF) begin
      @(posedge clk);
      #1;
      n++;
      if (fs_s) break;
    end
    chk("post_rst_frame_start_edges", n, SF);

    // Let the full-size instance run past its visible-window checkpoints.
    n = 0;
    while (tb_t < 36 * 800 && n < 40000) begin
      @(negedge clk);
      n++;
    end
    chk("big_run_reached_line36", tb_t >= 36 * 800, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_timing_ctrl.md
VGA_TIMING_CTRL -- requirements
Module: vga_timing_ctrl

Interface
REQ-001 SHALL have parameter H_SYNC, default 96, horizontal sync width in vga_clk cycles.
REQ-002 SHALL have parameters H_BACK 48, H_VALID 640, H_FRONT 16 (H_TOTAL = sum = 800).
REQ-003 SHALL have parameters V_SYNC 2, V_BACK 33, V_VALID 480, V_FRONT 10 (V_TOTAL = sum = 525), in lines.
REQ-004 SHALL have parameter PIC_W, default 100, sprite edge length used for position clamping.
REQ-005 SHALL have port vga_clk  in  1  pixel clock, 25 MHz, the only clock.
REQ-006 SHALL have port sys_rst  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have port pix_data  in  16  RGB565 pixel returned by the picture generator, one cycle after pix_x/pix_y.
REQ-008 SHALL have ports x_move_in, y_move_in  in  10 each  requested sprite top-left position.
REQ-009 SHALL have ports pix_x, pix_y  out  12 each  requested pixel coordinate, 12'hFFF when no request.
REQ-010 SHALL have ports x_move, y_move  out  10 each  frame-stable sprite position for the picture generator.
REQ-011 SHALL have ports hsync, vsync  out  1 each  active-high sync pulses.
REQ-012 SHALL have port de  out  1  display-enable, high on visible pixels.
REQ-013 SHALL have port rgb  out  16  RGB565 to the DAC.
REQ-014 SHALL have port frame_start  out  1  single-cycle pulse at the first cycle of each frame.

Function
REQ-015 cnt_h SHALL count 0..H_TOTAL-1 and wrap to 0; cnt_v SHALL increment when cnt_h wraps, count 0..V_TOTAL-1, and wrap to 0.
REQ-016 hsync SHALL be 1 iff cnt_h < H_SYNC; vsync SHALL be 1 iff cnt_v < V_SYNC (combinational from counters).
REQ-017 Visible window: h_act = cnt_h in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_VALID) = [144,784); v_act = cnt_v in [V_SYNC+V_BACK, +V_VALID) = [35,515).
REQ-018 Request window SHALL lead the visible window by exactly one cycle: pix_req = v_act and cnt_h in [143,783).
REQ-019 When pix_req = 1: pix_x = cnt_h - 143 and pix_y = cnt_v - 35, both zero-extended to 12 bits; otherwise both 12'hFFF.
REQ-020 de SHALL equal h_act and v_act.
REQ-021 rgb SHALL equal pix_data when de = 1 and 16'h0000 otherwise; no added register.
REQ-022 frame_start SHALL be a registered pulse, high for the one cycle in which cnt_h = 0 and cnt_v = 0.
REQ-023 x_move/y_move SHALL be registered from x_move_in/y_move_in only on the clock edge where cnt_h = H_TOTAL-1 and cnt_v = V_TOTAL-1, so they are constant for the entire following frame.
REQ-024 On capture: x_move = min(x_move_in, H_VALID-PIC_W) = min(., 540); y_move = min(y_move_in, V_VALID-PIC_W) = min(., 380). The comparison SHALL be unsigned at 10 bits.
REQ-025 Changes to x_move_in/y_move_in at any other cycle SHALL have no effect until the next capture edge.
REQ-026 Frame period SHALL be H_TOTAL*V_TOTAL = 420000 cycles, with no gaps or stalls.

Reset
REQ-027 While sys_rst = 1: cnt_h = 0, cnt_v = 0, x_move = 0, y_move = 0, frame_start = 0; hence hsync = 1, vsync = 1, de = 0, rgb = 0, pix_x = pix_y = 12'hFFF.
REQ-028 Reset asserted mid-frame SHALL take effect immediately (asynchronous); after deassertion, counting SHALL restart from cnt_h = 0, cnt_v = 0 on the first vga_clk edge.
REQ-029 The first frame_start after reset SHALL occur 420000 cycles after the first counting edge; the reset state itself does not pulse.

Verification
REQ-030 Release reset, run 2 lines -> hsync high for 96 cycles per 800-cycle line; vsync high for lines 0-1 only.
REQ-031 Line 35, cnt_h = 143 -> pix_x = 0, pix_y = 0, de = 0. At cnt_h = 144 -> de = 1, rgb = pix_data. At cnt_h = 782 -> pix_x = 639. At cnt_h = 783 -> pix_x = 12'hFFF, de = 1. At cnt_h = 784 -> de = 0.
REQ-032 x_move_in = 600, y_move_in = 50 before the frame boundary -> after the capture edge, x_move = 540 and y_move = 50.
REQ-033 Change x_move_in from 10 to 200 at line 100 -> x_move stays 10 until the capture edge, then becomes 200.
REQ-034 Assert sys_rst at cnt_h = 500, line 200 -> outputs immediately take REQ-027 values; after release, frame_start pulses 420000 cycles later.
REQ-035 Drive pix_data = 16'hF800 constantly for one full frame -> exactly 307200 cycles with de = 1 and rgb = 16'hF800; all other cycles rgb = 0.
